tdm_demux: RTL and testbench

Time-division demultiplexer: the receiving end of a time-multiplexed link whose transmit side selects one of several sources per beat. A serial stream of `WIDTH`-bit beats, with a sync marker on the channel-0 beat, is split back into `CHANNELS` registered parallel outputs, each with a one-cycle valid strobe. It sits downstream of the select-driven mux stage and locks to the frame using the sync marker.

---
 rtl/tdm_demux.sv | 177 +++++++++++++++++
 tb/tb_tdm_demux.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
// ---------------------------------------------------------------------------
// tdm_demux
//
// Receiving end of a time-multiplexed link. A serial stream of WIDTH-bit
// beats, with a sync marker on the channel-0 beat, is split back into
// CHANNELS registered parallel outputs. The block hunts for the sync marker,
// locks to the frame and then writes each accepted beat to the next slot.
// Framing violations (missing or early sync) pulse sync_err.
//
// Ports:
//   clk         single clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    a beat is present on in_data
//   in_sync     current beat is slot 0 (ignored when in_valid = 0)
//   in_data     beat payload
//   ch_data     channel k at bits [k*WIDTH +: WIDTH], held between writes
//   ch_valid    bit k pulses for one cycle when channel k is written
//   frame_done  pulses when the last slot of a frame is written
//   locked      high while locked to the frame
//   sync_err    pulses on any framing violation
//   slot        slot the next accepted beat will be written to
//
// All outputs are registered; one beat is accepted per cycle.
// CHANNELS must lie in 2..16.
// ---------------------------------------------------------------------------
module tdm_demux #(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 2,
    localparam int SW       = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic                      in_sync,
    input  logic [WIDTH-1:0]          in_data,
    output logic [CHANNELS*WIDTH-1:0] ch_data,
    output logic [CHANNELS-1:0]       ch_valid,
    output logic                      frame_done,
    output logic                      locked,
    output logic                      sync_err,
    output logic [SW-1:0]             slot
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [SW-1:0] SLOT_ZERO = '0;
    localparam logic [SW-1:0] SLOT_ONE  = SW'(1);
    localparam logic [SW-1:0] LAST_SLOT = SW'(CHANNELS - 1);

    // -----------------------------------------------------------------------
    // Framing state
    // -----------------------------------------------------------------------
    state_t          state_reg;
    state_t          state_next;
    logic [SW-1:0]   slot_reg;
    logic [SW-1:0]   slot_next;
    logic            frame_done_reg;
    logic            frame_done_next;
    logic            sync_err_reg;
    logic            sync_err_next;

    // Write request shared by all channel registers
    logic            wr_en;
    logic [SW-1:0]   wr_idx;

    // -----------------------------------------------------------------------
    // Next-state decode. Nothing changes on cycles without a beat, so the
    // whole decode sits under in_valid.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        slot_next       = slot_reg;
        frame_done_next = 1'b0;
        sync_err_next   = 1'b0;
        wr_en           = 1'b0;
        wr_idx          = SLOT_ZERO;

        if (in_valid) begin
            case (state_reg)
                HUNT: begin
                    // Beats without sync are dropped until the marker shows up.
                    if (in_sync) begin
                        wr_en      = 1'b1;
                        wr_idx     = SLOT_ZERO;
                        slot_next  = SLOT_ONE;
                        state_next = LOCKED;
                    end
                end

                LOCKED: begin
                    if (in_sync) begin
                        // Sync always restarts the frame at slot 0. Seen
                        // anywhere but slot 0 it is an early sync: the
                        // truncated frame is abandoned without frame_done.
                        wr_en         = 1'b1;
                        wr_idx        = SLOT_ZERO;
                        slot_next     = SLOT_ONE;
                        sync_err_next = (slot_reg != SLOT_ZERO);
                    end else if (slot_reg == SLOT_ZERO) begin
                        // Missing sync: lose lock and drop the beat.
                        sync_err_next = 1'b1;
                        state_next    = HUNT;
                        slot_next     = SLOT_ZERO;
                    end else begin
                        wr_en  = 1'b1;
                        wr_idx = slot_reg;
                        // Explicit wrap keeps slot inside 0..CHANNELS-1 for
                        // non-power-of-two channel counts.
                        if (slot_reg == LAST_SLOT) begin
                            slot_next       = SLOT_ZERO;
                            frame_done_next = 1'b1;
                        end else begin
                            slot_next = slot_reg + SLOT_ONE;
                        end
                    end
                end

                default: begin
                    state_next = HUNT;
                    slot_next  = SLOT_ZERO;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= HUNT;
            slot_reg       <= SLOT_ZERO;
            frame_done_reg <= 1'b0;
            sync_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            slot_reg       <= slot_next;
            frame_done_reg <= frame_done_next;
            sync_err_reg   <= sync_err_next;
        end
    end

    assign locked     = (state_reg == LOCKED);
    assign slot       = slot_reg;
    assign frame_done = frame_done_reg;
    assign sync_err   = sync_err_reg;

    // -----------------------------------------------------------------------
    // Per-channel output registers. Each channel decodes its own write
    // select, so at most one ch_valid bit can be high in any cycle.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic             hit;
            logic             valid_reg;
            logic [WIDTH-1:0] data_reg;

            assign hit = wr_en && (wr_idx == SW'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                end else begin
                    valid_reg <= hit;
                    if (hit) begin
                        data_reg <= in_data;
                    end
                end
            end

            assign ch_valid[gi]                 = valid_reg;
            assign ch_data[gi*WIDTH +: WIDTH]   = data_reg;
        end
    endgenerate

endmodule

// File: tb/tb_tdm_demux.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux
//
// Drives one CHANNELS=2 and one CHANNELS=3 instance of tdm_demux with the
// same beat stream and compares every output against a frame-level model
// after each clock edge. Directed scenarios come first, then random traffic
// with one asynchronous mid-stream reset.
// ---------------------------------------------------------------------------
module tb_tdm_demux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sync = 1'b0;
    logic [7:0]  in_data = 8'h00;

    logic [15:0] d2;
    logic [1:0]  v2;
    logic        done2, lock2, err2;
    logic [0:0]  slot2;

    logic [23:0] d3;
    logic [2:0]  v3;
    logic        done3, lock3, err3;
    logic [1:0]  slot3;

    always #5 clk = ~clk;

    tdm_demux #(.WIDTH(8), .CHANNELS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sync(in_sync),
        .in_data(in_data), .ch_data(d2), .ch_valid(v2), .frame_done(done2),
        .locked(lock2), .sync_err(err2), .slot(slot2)
    );

    tdm_demux #(.WIDTH(8), .CHANNELS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sync(in_sync),
        .in_data(in_data), .ch_data(d3), .ch_valid(v3), .frame_done(done3),
        .locked(lock3), .sync_err(err3), .slot(slot3)
    );

    // ---------------- reference model (index 0: 2 channels, 1: 3 channels)
    int          total = 0;
    int          bad = 0;
    int          nch_of [2] = '{2, 3};
    bit          m_lock [2];
    int          m_pos  [2];
    logic [7:0]  m_data [2][16];
    logic [15:0] m_val  [2];
    bit          m_done [2];
    bit          m_err  [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_lock[k] = 0;
            m_pos[k]  = 0;
            m_val[k]  = '0;
            m_done[k] = 0;
            m_err[k]  = 0;
            for (int c = 0; c < 16; c++) m_data[k][c] = 8'h00;
        end
    endtask

    // One accepted edge of the frame rules for instance k.
    task automatic model_step(input int k, input bit v, input bit s, input logic [7:0] d);
        int n;
        n = nch_of[k];
        m_val[k]  = '0;
        m_done[k] = 0;
        m_err[k]  = 0;
        if (v) begin
            if (s) begin
                // Sync restarts the frame; it is an error only mid-frame.
                if (m_lock[k] && m_pos[k] != 0) m_err[k] = 1;
                m_data[k][0] = d;
                m_val[k][0]  = 1'b1;
                m_lock[k]    = 1;
                m_pos[k]     = 1;
            end else if (m_lock[k]) begin
                if (m_pos[k] == 0) begin
                    m_err[k]  = 1;
                    m_lock[k] = 0;
                end else begin
                    m_data[k][m_pos[k]] = d;
                    m_val[k][m_pos[k]]  = 1'b1;
                    if (m_pos[k] == n - 1) m_done[k] = 1;
                    m_pos[k] = (m_pos[k] + 1) % n;
                end
            end
        end
    endtask

    function automatic logic [63:0] exp_data(input int k);
        logic [63:0] r;
        r = '0;
        for (int c = 0; c < nch_of[k]; c++) r[c*8 +: 8] = m_data[k][c];
        return r;
    endfunction

    task automatic check_all();
        check("data_c2",  d2,    exp_data(0));
        check("valid_c2", v2,    m_val[0]);
        check("done_c2",  done2, m_done[0]);
        check("lock_c2",  lock2, m_lock[0]);
        check("err_c2",   err2,  m_err[0]);
        check("slot_c2",  slot2, m_pos[0]);
        check("data_c3",  d3,    exp_data(1));
        check("valid_c3", v3,    m_val[1]);
        check("done_c3",  done3, m_done[1]);
        check("lock_c3",  lock3, m_lock[1]);
        check("err_c3",   err3,  m_err[1]);
        check("slot_c3",  slot3, m_pos[1]);
    endtask

    // Present a beat, let one edge pass, then compare. Entered and left at
    // posedge+1.
    task automatic beat(input bit v, input bit s, input logic [7:0] d);
        in_valid = v;
        in_sync  = s;
        in_data  = d;
        @(posedge clk);
        model_step(0, v, s, d);
        model_step(1, v, s, d);
        #1;
        check_all();
        $display("beat v=%0d s=%0d d=%02h | c2 lock=%0d slot=%0d val=%b | c3 lock=%0d slot=%0d val=%b",
                 v, s, d, lock2, slot2, v2, lock3, slot3, v3);
    endtask

    // Reset asserted between edges must clear outputs before the next edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        in_valid = 1'b0;
        in_sync  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-frame, then sync-less beats while hunting
        beat(1, 1, 8'h55);
        async_reset();
        beat(1, 0, 8'h11);
        beat(1, 0, 8'h22);
        check("hunt_data", d2, 16'h0000);
        check("hunt_lock", lock2, 1'b0);

        // Lock and frame, back-to-back
        beat(1, 1, 8'hA5);
        check("lock_valid", v2, 2'b01);
        check("lock_slot", slot2, 1'b1);
        beat(1, 0, 8'h3C);
        check("frame_done", done2, 1'b1);
        check("frame_data", d2, 16'h3CA5);

        // Same frame with idle gaps
        beat(1, 1, 8'hA5);
        repeat (3) beat(0, 0, 8'($urandom));
        beat(1, 0, 8'h3C);
        repeat (3) beat(0, 1, 8'($urandom));

        // Missing sync at slot 0
        beat(1, 0, 8'h77);
        check("miss_err", err2, 1'b1);
        check("miss_data", d2, 16'h3CA5);
        beat(0, 0, 8'h00);

        // Early sync at slot 1
        beat(1, 1, 8'hA5);
        beat(1, 1, 8'h99);
        check("early_err", err2, 1'b1);
        check("early_valid", v2, 2'b01);
        check("early_done", done2, 1'b0);
        check("early_lock", lock2, 1'b1);

        // Three-channel frames
        repeat (2) begin
            beat(1, 1, 8'h01);
            beat(1, 0, 8'h02);
            beat(1, 0, 8'h03);
            check("c3_done", done3, 1'b1);
        end
        check("c3_data", d3, 24'h030201);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if (i == 300) async_reset();
            beat(($urandom % 4) != 0, ($urandom % 3) == 0, 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
